// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-lite register-file slave:
// FSM state encodings, response codes and the address range check.
package axi_lite_pkg;

   typedef enum logic [1:0] {
      W_IDLE      = 2'b00,
      W_HAVE_ADDR = 2'b01,
      W_HAVE_DATA = 2'b10,
      W_RESP      = 2'b11
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   // One extra bit of headroom so base+depth cannot wrap for any address width up to 32.
   function automatic logic in_range(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
      logic [32:0] a_ext;
      logic [32:0] lo_ext;
      logic [32:0] hi_ext;
      a_ext  = {1'b0, addr};
      lo_ext = {1'b0, base};
      hi_ext = {1'b0, base} + {1'b0, depth};
      return (a_ext >= lo_ext) && (a_ext < hi_ext);
   endfunction

endpackage

// File: rtl/axi_lite_reg_array.sv
// DEPTH x DATA_W register storage: one synchronous write port, one registered
// read port that returns pre-write data on a same-edge collision.
module axi_lite_reg_array
   import axi_lite_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned IDX_W  = 6
) (
   input  logic              A_clk,
   input  logic              A_reset,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_hit,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   // Next storage contents and read-port capture; a miss loads zero, idle holds.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         mem_d[i] = (wr_en && (wr_idx == IDX_W'(i))) ? wr_data : mem_q[i];
      end
      if (rd_en && rd_hit) begin
         rd_data_d = mem_q[rd_idx];
      end else if (rd_en) begin
         rd_data_d = '0;
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Storage and read-data flops with synchronous clear.
   always_ff @(posedge A_clk) begin
      if (A_reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// AXI-lite slave terminating AW/W/B and AR/R onto a register bank at
// BASE_ADDR..BASE_ADDR+DEPTH-1; independent write and read state machines.
module axi_lite_slave_regfile
   import axi_lite_pkg::*;
#(
   parameter int unsigned          ADDR_W    = 8,
   parameter int unsigned          DATA_W    = 8,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = 8'h40,
   parameter int unsigned          DEPTH     = 64
) (
   input  logic              A_clk,
   input  logic              A_reset,
   input  logic [ADDR_W-1:0] AW_addr,
   input  logic              AW_valid,
   output logic              AW_ready,
   input  logic [DATA_W-1:0] W_data,
   input  logic              W_valid,
   output logic              W_ready,
   output logic              B_resp,
   output logic              B_valid,
   input  logic              B_ready,
   input  logic [ADDR_W-1:0] AR_addr,
   input  logic              AR_valid,
   output logic              AR_ready,
   output logic [DATA_W-1:0] R_data,
   output logic              R_resp,
   output logic              R_valid,
   input  logic              R_ready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   w_state_e          w_state_q, w_state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              b_resp_q, b_resp_d;
   logic              b_valid_q, b_valid_d;
   r_state_e          r_state_q, r_state_d;
   logic              r_resp_q, r_resp_d;
   logic              r_valid_q, r_valid_d;

   logic              aw_ready_s, w_ready_s, ar_ready_s;
   logic              aw_hs_s, w_hs_s, ar_hs_s;
   logic              commit_s, commit_hit_s, rd_hit_s;
   logic [ADDR_W-1:0] commit_addr_s;
   logic [DATA_W-1:0] commit_data_s;

   // Readies decode state only; reset masks them so nothing is accepted while held.
   always_comb begin
      aw_ready_s = !A_reset && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA));
      w_ready_s  = !A_reset && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR));
      ar_ready_s = !A_reset && (r_state_q == R_IDLE);
      aw_hs_s    = AW_valid && aw_ready_s;
      w_hs_s     = W_valid && w_ready_s;
      ar_hs_s    = AR_valid && ar_ready_s;
   end

   // Write FSM: gather address and data in either order, commit on entry to W_RESP.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               w_state_d = W_RESP;
            end else if (aw_hs_s) begin
               w_state_d = W_HAVE_ADDR;
            end else if (w_hs_s) begin
               w_state_d = W_HAVE_DATA;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_HAVE_ADDR: w_state_d = w_hs_s  ? W_RESP : W_HAVE_ADDR;
         W_HAVE_DATA: w_state_d = aw_hs_s ? W_RESP : W_HAVE_DATA;
         W_RESP:      w_state_d = B_ready ? W_IDLE : W_RESP;
         default:     w_state_d = W_IDLE;
      endcase

      waddr_d       = aw_hs_s ? AW_addr : waddr_q;
      wdata_d       = w_hs_s  ? W_data  : wdata_q;
      commit_addr_s = aw_hs_s ? AW_addr : waddr_q;
      commit_data_s = w_hs_s  ? W_data  : wdata_q;
      commit_s      = (w_state_q != W_RESP) && (w_state_d == W_RESP);
      commit_hit_s  = in_range(32'(commit_addr_s), 32'(BASE_ADDR), 32'(DEPTH));
      if (commit_s) begin
         b_resp_d = commit_hit_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
         b_resp_d = b_resp_q;
      end
      b_valid_d = (w_state_d == W_RESP);
   end

   // Read FSM: capture on AR, hold the beat until R_ready.
   always_comb begin
      r_state_d = r_state_q;
      r_resp_d  = r_resp_q;
      rd_hit_s  = in_range(32'(AR_addr), 32'(BASE_ADDR), 32'(DEPTH));
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs_s) begin
               r_state_d = R_DATA;
               r_resp_d  = rd_hit_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_DATA:  r_state_d = R_ready ? R_IDLE : R_DATA;
         default: r_state_d = R_IDLE;
      endcase
      r_valid_d = (r_state_d == R_DATA);
   end

   // State and output registers.
   always_ff @(posedge A_clk) begin
      if (A_reset) begin
         w_state_q <= W_IDLE;
         waddr_q   <= '0;
         wdata_q   <= '0;
         b_resp_q  <= 1'b0;
         b_valid_q <= 1'b0;
         r_state_q <= R_IDLE;
         r_resp_q  <= 1'b0;
         r_valid_q <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         b_resp_q  <= b_resp_d;
         b_valid_q <= b_valid_d;
         r_state_q <= r_state_d;
         r_resp_q  <= r_resp_d;
         r_valid_q <= r_valid_d;
      end
   end

   axi_lite_reg_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .A_clk   (A_clk),
      .A_reset (A_reset),
      .wr_en   (commit_s && commit_hit_s),
      .wr_idx  (IDX_W'(commit_addr_s - BASE_ADDR)),
      .wr_data (commit_data_s),
      .rd_en   (ar_hs_s),
      .rd_hit  (rd_hit_s),
      .rd_idx  (IDX_W'(AR_addr - BASE_ADDR)),
      .rd_data (R_data)
   );

   assign AW_ready = aw_ready_s;
   assign W_ready  = w_ready_s;
   assign AR_ready = ar_ready_s;
   assign B_resp   = b_resp_q;
   assign B_valid  = b_valid_q;
   assign R_resp   = r_resp_q;
   assign R_valid  = r_valid_q;

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed plus randomized bench for axi_lite_slave_regfile against a flat
// 256-entry memory model that applies the mapping rules directly.
module tb_axi_lite_slave_regfile;

   logic       A_clk = 1'b0;
   logic       A_reset;
   logic [7:0] AW_addr, W_data, AR_addr, R_data;
   logic       AW_valid, AW_ready, W_valid, W_ready;
   logic       B_resp, B_valid, B_ready;
   logic       AR_valid, AR_ready, R_resp, R_valid, R_ready;

   int errors = 0;
   int checks = 0;
   logic [7:0] model [0:255];

   axi_lite_slave_regfile dut (
      .A_clk(A_clk), .A_reset(A_reset),
      .AW_addr(AW_addr), .AW_valid(AW_valid), .AW_ready(AW_ready),
      .W_data(W_data), .W_valid(W_valid), .W_ready(W_ready),
      .B_resp(B_resp), .B_valid(B_valid), .B_ready(B_ready),
      .AR_addr(AR_addr), .AR_valid(AR_valid), .AR_ready(AR_ready),
      .R_data(R_data), .R_resp(R_resp), .R_valid(R_valid), .R_ready(R_ready)
   );

   always #5 A_clk = ~A_clk;

   function automatic bit mapped(input logic [7:0] a);
      return (a >= 8'h40) && (a < 8'h80);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge A_clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit   aw_done = 1'b0;
      bit   w_done  = 1'b0;
      bit   aw_hs, w_hs;
      int   cyc = 0;
      logic exp_resp;
      exp_resp = mapped(a) ? 1'b0 : 1'b1;
      AW_addr  = a;
      W_data   = d;
      B_ready  = 1'b0;
      while (!(aw_done && w_done) && cyc < 50) begin
         AW_valid = !aw_done && (cyc >= aw_dly);
         W_valid  = !w_done && (cyc >= w_dly);
         chk("b_valid_early", B_valid, 1'b0);
         if (aw_done) begin
            chk("aw_ready_after_aw", AW_ready, 1'b0);
            chk("w_ready_after_aw", W_ready, 1'b1);
         end
         if (w_done) begin
            chk("aw_ready_after_w", AW_ready, 1'b1);
            chk("w_ready_after_w", W_ready, 1'b0);
         end
         aw_hs = AW_valid && AW_ready;
         w_hs  = W_valid && W_ready;
         step();
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done  = 1'b1;
         cyc++;
      end
      AW_valid = 1'b0;
      W_valid  = 1'b0;
      chk("write_accept_timeout", {31'd0, aw_done && w_done}, 32'd1);
      if (!exp_resp) model[a] = d;
      chk("b_valid_rise", B_valid, 1'b1);
      chk("b_resp", B_resp, exp_resp);
      for (int i = 0; i < b_dly; i++) begin
         step();
         chk("b_valid_hold", B_valid, 1'b1);
         chk("b_resp_hold", B_resp, exp_resp);
         chk("aw_ready_in_resp", AW_ready, 1'b0);
         chk("w_ready_in_resp", W_ready, 1'b0);
      end
      B_ready = 1'b1;
      step();
      B_ready = 1'b0;
      chk("b_valid_drop", B_valid, 1'b0);
      chk("aw_ready_back", AW_ready, 1'b1);
   endtask

   task automatic do_read(input logic [7:0] a, input int r_dly);
      bit         hs = 1'b0;
      int         cyc = 0;
      logic [7:0] exp_d;
      logic       exp_r;
      AR_addr = a;
      R_ready = 1'b0;
      while (!hs && cyc < 50) begin
         AR_valid = 1'b1;
         chk("r_valid_early", R_valid, 1'b0);
         hs = AR_ready;
         step();
         cyc++;
      end
      AR_valid = 1'b0;
      chk("read_accept_timeout", {31'd0, hs}, 32'd1);
      exp_d = mapped(a) ? model[a] : 8'h00;
      exp_r = mapped(a) ? 1'b0 : 1'b1;
      chk("r_valid_rise", R_valid, 1'b1);
      chk("r_data", R_data, exp_d);
      chk("r_resp", R_resp, exp_r);
      for (int i = 0; i < r_dly; i++) begin
         step();
         chk("r_valid_hold", R_valid, 1'b1);
         chk("r_data_hold", R_data, exp_d);
         chk("r_resp_hold", R_resp, exp_r);
         chk("ar_ready_in_data", AR_ready, 1'b0);
      end
      R_ready = 1'b1;
      step();
      R_ready = 1'b0;
      chk("r_valid_drop", R_valid, 1'b0);
      chk("ar_ready_back", AR_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] old_v;
      logic [7:0] ra, rd;
      clear_model();
      A_reset  = 1'b1;
      AW_valid = 1'b1; W_valid = 1'b1; AR_valid = 1'b1;
      B_ready  = 1'b1; R_ready = 1'b1;
      AW_addr  = 8'h45; W_data = 8'h99; AR_addr = 8'h45;

      // reset held with every valid asserted
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_aw_ready", AW_ready, 1'b0);
         chk("rst_w_ready", W_ready, 1'b0);
         chk("rst_ar_ready", AR_ready, 1'b0);
         chk("rst_b_valid", B_valid, 1'b0);
         chk("rst_r_valid", R_valid, 1'b0);
         chk("rst_b_resp", B_resp, 1'b0);
         chk("rst_r_resp", R_resp, 1'b0);
         chk("rst_r_data", R_data, 8'h00);
      end
      AW_valid = 1'b0; W_valid = 1'b0; AR_valid = 1'b0;
      B_ready  = 1'b0; R_ready = 1'b0;
      A_reset  = 1'b0;
      step();
      chk("post_rst_aw_ready", AW_ready, 1'b1);
      chk("post_rst_w_ready", W_ready, 1'b1);
      chk("post_rst_ar_ready", AR_ready, 1'b1);

      do_write(8'h45, 8'h23, 0, 0, 0);
      do_read(8'h45, 0);
      do_write(8'h65, 8'h34, 0, 2, 0);
      do_read(8'h65, 0);
      do_write(8'h50, 8'hAA, 0, 0, 4);
      do_read(8'h50, 3);
      do_write(8'h90, 8'h11, 0, 0, 0);
      do_read(8'h90, 0);
      do_read(8'h3F, 0);
      do_read(8'h50, 0);
      do_write(8'h7F, 8'h5C, 1, 0, 1);
      do_read(8'h7F, 0);
      do_read(8'h80, 0);

      // write commit and read handshake for the same address on the same edge
      old_v   = model[8'h45];
      AW_addr = 8'h45; W_data = 8'h77; AR_addr = 8'h45;
      AW_valid = 1'b1; W_valid = 1'b1; AR_valid = 1'b1;
      step();
      AW_valid = 1'b0; W_valid = 1'b0; AR_valid = 1'b0;
      model[8'h45] = 8'h77;
      chk("coll_b_valid", B_valid, 1'b1);
      chk("coll_b_resp", B_resp, 1'b0);
      chk("coll_r_valid", R_valid, 1'b1);
      chk("coll_r_data_old", R_data, old_v);
      chk("coll_r_resp", R_resp, 1'b0);
      B_ready = 1'b1; R_ready = 1'b1;
      step();
      B_ready = 1'b0; R_ready = 1'b0;
      chk("coll_b_drop", B_valid, 1'b0);
      chk("coll_r_drop", R_valid, 1'b0);
      do_read(8'h45, 0);

      // reset while the write path holds only an address
      AW_addr = 8'h45; AW_valid = 1'b1;
      step();
      AW_valid = 1'b0;
      chk("half_aw_ready", AW_ready, 1'b0);
      chk("half_w_ready", W_ready, 1'b1);
      A_reset = 1'b1; W_data = 8'h55; W_valid = 1'b1; B_ready = 1'b1;
      step();
      chk("midrst_b_valid", B_valid, 1'b0);
      chk("midrst_w_ready", W_ready, 1'b0);
      step();
      A_reset = 1'b0; W_valid = 1'b0; B_ready = 1'b0;
      clear_model();
      step();
      chk("after_rst_b_valid", B_valid, 1'b0);
      chk("after_rst_aw_ready", AW_ready, 1'b1);
      chk("after_rst_w_ready", W_ready, 1'b1);
      do_read(8'h45, 0);
      do_read(8'h65, 0);

      // randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         ra = 8'($urandom_range(8'h38, 8'h88));
         rd = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            do_write(ra, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)));
         end else begin
            do_read(ra, int'($urandom_range(0, 2)));
         end
      end
      for (int n = 0; n < 8; n++) begin
         do_read(8'($urandom_range(8'h40, 8'h7F)), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
